// File: rtl/ram2_ctrl_pkg.sv
// Shared types and defaults for the RAM2 asynchronous SRAM controller.
package ram2_ctrl_pkg;

  localparam int          RAM2_ADDR_W  = 18;
  localparam int          RAM2_DATA_W  = 16;
  localparam logic [15:0] NOP_INST_DEF = 16'h0800;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_READ     = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4
  } ram2_state_t;

  function automatic logic is_wr_state(input ram2_state_t s);
    return (s == S_WR_SETUP) || (s == S_WR_PULSE) || (s == S_WR_HOLD);
  endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// Pipeline-side signals of the RAM2 controller: IF fetch path and MEM-stage access.
interface ram2_ctrl_if;

  logic [15:0] pc_i;
  logic [15:0] if_inst_o;
  logic        mem_ce_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_data_i;
  logic [15:0] mem_data_o;
  logic        stallreq_o;

  modport slave (
    input  pc_i, mem_ce_i, mem_re_i, mem_we_i, mem_addr_i, mem_data_i,
    output if_inst_o, mem_data_o, stallreq_o
  );

  modport master (
    output pc_i, mem_ce_i, mem_re_i, mem_we_i, mem_addr_i, mem_data_i,
    input  if_inst_o, mem_data_o, stallreq_o
  );

endinterface

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM controller: fetches instructions by default, stalls the pipeline to
// slot in MEM loads/stores with non-overlapping OE/WE timing.
//
// state      | meaning
// S_FETCH    | address = pc, OE low, instruction passes straight to IF
// S_READ     | address = mem_addr, OE low, load data captured at the edge
// S_WR_SETUP | address/data driven, OE and WE high
// S_WR_PULSE | WE low, SRAM latches on its rising edge
// S_WR_HOLD  | WE back high, address/data held one more cycle
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = RAM2_ADDR_W,
  parameter int                DATA_W   = RAM2_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ram2_ctrl_if.slave        pipe,
  output logic [ADDR_W-1:0] ram2_addr_o,
  inout  wire  [DATA_W-1:0] ram2_data_io,
  output logic              ram2_oe_n,
  output logic              ram2_we_n,
  output logic              ram2_en_n
);

  ram2_state_t       state;
  ram2_state_t       state_nxt;
  logic              done;
  logic              done_nxt;
  logic              drv_en;
  logic              req;
  logic [DATA_W-1:0] mem_data_q;

  assign req             = pipe.mem_ce_i & (pipe.mem_re_i | pipe.mem_we_i);
  assign pipe.stallreq_o = req & ~done;
  assign pipe.mem_data_o = mem_data_q;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_FETCH: begin
        if (req && !done)
          state_nxt = pipe.mem_we_i ? S_WR_SETUP : S_READ;
      end
      S_READ: begin
        state_nxt = S_FETCH;
        done_nxt  = 1'b1;
      end
      S_WR_SETUP: state_nxt = S_WR_PULSE;
      S_WR_PULSE: state_nxt = S_WR_HOLD;
      S_WR_HOLD: begin
        state_nxt = S_FETCH;
        done_nxt  = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Pin controls are registered from the next state so they change with the
  // state register and clear asynchronously with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      done       <= 1'b0;
      mem_data_q <= '0;
      ram2_oe_n  <= 1'b1;
      ram2_we_n  <= 1'b1;
      ram2_en_n  <= 1'b1;
      drv_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      done      <= done_nxt;
      ram2_en_n <= 1'b0;
      ram2_oe_n <= !((state_nxt == S_FETCH) || (state_nxt == S_READ));
      ram2_we_n <= (state_nxt != S_WR_PULSE);
      drv_en    <= is_wr_state(state_nxt);
      if (state == S_READ)
        mem_data_q <= ram2_data_io;
    end
  end

  assign ram2_addr_o = {{(ADDR_W-16){1'b0}},
                        (state == S_FETCH) ? pipe.pc_i : pipe.mem_addr_i};

  // Gating on oe_n keeps IF on NOP during reset, when the bus is floating.
  assign pipe.if_inst_o = ((state == S_FETCH) && !ram2_oe_n) ? ram2_data_io : NOP_INST;

  assign ram2_data_io = drv_en ? pipe.mem_data_i : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed bench for ram2_ctrl with an inline asynchronous SRAM model.
module tb_ram2_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] ram2_addr;
  wire  [15:0] ram2_data;
  logic        ram2_oe_n;
  logic        ram2_we_n;
  logic        ram2_en_n;
  logic [15:0] sram [0:1023];

  int checks   = 0;
  int failures = 0;

  ram2_ctrl_if pif ();

  ram2_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pipe         (pif.slave),
    .ram2_addr_o  (ram2_addr),
    .ram2_data_io (ram2_data),
    .ram2_oe_n    (ram2_oe_n),
    .ram2_we_n    (ram2_we_n),
    .ram2_en_n    (ram2_en_n)
  );

  always #5 clk = ~clk;

  // Async SRAM: reads while selected with OE low, latches on WE rising while selected.
  assign ram2_data = (!ram2_en_n && !ram2_oe_n && ram2_we_n) ? sram[ram2_addr[9:0]] : 16'hzzzz;

  always @(posedge ram2_we_n) begin
    if (ram2_en_n === 1'b0)
      sram[ram2_addr[9:0]] = ram2_data;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst)
      check_val("oe_we_exclusive", {31'b0, (!ram2_oe_n && !ram2_we_n)}, 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    pif.mem_ce_i = 1'b0;
    pif.mem_re_i = 1'b0;
    pif.mem_we_i = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] addr, input logic [15:0] exp_data, input logic [15:0] exp_inst);
    cyc();
    pif.mem_ce_i   = 1'b1;
    pif.mem_re_i   = 1'b1;
    pif.mem_we_i   = 1'b0;
    pif.mem_addr_i = addr;
    @(negedge clk);
    check_val("ld_entry_stall", {31'b0, pif.stallreq_o}, 32'd1);
    cyc();
    @(negedge clk);
    check_val("ld_read_stall", {31'b0, pif.stallreq_o}, 32'd1);
    check_val("ld_read_addr", {14'b0, ram2_addr}, {16'b0, addr});
    check_val("ld_read_oe_n", {31'b0, ram2_oe_n}, 32'd0);
    check_val("ld_read_inst_nop", {16'b0, pif.if_inst_o}, 32'h0800);
    cyc();
    @(negedge clk);
    check_val("ld_release_stall", {31'b0, pif.stallreq_o}, 32'd0);
    check_val("ld_release_data", {16'b0, pif.mem_data_o}, {16'b0, exp_data});
    check_val("ld_release_fetch", {16'b0, pif.if_inst_o}, {16'b0, exp_inst});
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [15:0] data, input logic re_too,
                          input logic [15:0] exp_mem_data);
    cyc();
    pif.mem_ce_i   = 1'b1;
    pif.mem_re_i   = re_too;
    pif.mem_we_i   = 1'b1;
    pif.mem_addr_i = addr;
    pif.mem_data_i = data;
    @(negedge clk);
    check_val("st_entry_stall", {31'b0, pif.stallreq_o}, 32'd1);
    check_val("st_entry_we_n", {31'b0, ram2_we_n}, 32'd1);
    cyc();
    @(negedge clk);
    check_val("st_setup_stall", {31'b0, pif.stallreq_o}, 32'd1);
    check_val("st_setup_oe_n", {31'b0, ram2_oe_n}, 32'd1);
    check_val("st_setup_we_n", {31'b0, ram2_we_n}, 32'd1);
    check_val("st_setup_bus", {16'b0, ram2_data}, {16'b0, data});
    check_val("st_setup_addr", {14'b0, ram2_addr}, {16'b0, addr});
    check_val("st_setup_inst_nop", {16'b0, pif.if_inst_o}, 32'h0800);
    cyc();
    @(negedge clk);
    check_val("st_pulse_we_n", {31'b0, ram2_we_n}, 32'd0);
    check_val("st_pulse_bus", {16'b0, ram2_data}, {16'b0, data});
    cyc();
    @(negedge clk);
    check_val("st_hold_stall", {31'b0, pif.stallreq_o}, 32'd1);
    check_val("st_hold_we_n", {31'b0, ram2_we_n}, 32'd1);
    check_val("st_hold_bus", {16'b0, ram2_data}, {16'b0, data});
    cyc();
    @(negedge clk);
    check_val("st_release_stall", {31'b0, pif.stallreq_o}, 32'd0);
    check_val("st_release_oe_n", {31'b0, ram2_oe_n}, 32'd0);
    check_val("st_release_mem_data", {16'b0, pif.mem_data_o}, {16'b0, exp_mem_data});
    check_val("st_sram_content", {16'b0, sram[addr[9:0]]}, {16'b0, data});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
    sram[10'h010] = 16'h6911;
    sram[10'h123] = 16'hBEEF;
    sram[10'h001] = 16'hA001;
    sram[10'h002] = 16'hB002;
    pif.pc_i       = 16'h0000;
    pif.mem_addr_i = 16'h0000;
    pif.mem_data_i = 16'h0000;
    idle_bus();

    #1 rst = 1'b0;
    #2;
    check_val("rst_en_n", {31'b0, ram2_en_n}, 32'd1);
    check_val("rst_we_n", {31'b0, ram2_we_n}, 32'd1);
    check_val("rst_oe_n", {31'b0, ram2_oe_n}, 32'd1);
    check_val("rst_mem_data", {16'b0, pif.mem_data_o}, 32'd0);
    check_val("rst_inst_nop", {16'b0, pif.if_inst_o}, 32'h0800);
    check_val("rst_stall", {31'b0, pif.stallreq_o}, 32'd0);
    cyc();
    rst = 1'b1;

    // plain fetch
    cyc();
    pif.pc_i = 16'h0010;
    @(negedge clk);
    check_val("fetch_inst", {16'b0, pif.if_inst_o}, 32'h6911);
    check_val("fetch_stall", {31'b0, pif.stallreq_o}, 32'd0);
    check_val("fetch_we_n", {31'b0, ram2_we_n}, 32'd1);
    check_val("fetch_en_n", {31'b0, ram2_en_n}, 32'd0);
    check_val("fetch_addr", {14'b0, ram2_addr}, 32'h0010);

    do_load(16'h0123, 16'hBEEF, 16'h6911);
    cyc(); idle_bus();

    do_store(16'h0200, 16'h1234, 1'b0, 16'hBEEF);
    cyc(); idle_bus();
    do_load(16'h0200, 16'h1234, 16'h6911);

    // back-to-back loads: request stays high straight through the release cycle
    do_load(16'h0001, 16'hA001, 16'h6911);
    do_load(16'h0002, 16'hB002, 16'h6911);
    cyc(); idle_bus();

    // read and write together behave as a write
    do_store(16'h0300, 16'h5555, 1'b1, 16'hB002);
    cyc(); idle_bus();

    // reset in the middle of the write pulse
    cyc();
    pif.mem_ce_i   = 1'b1;
    pif.mem_we_i   = 1'b1;
    pif.mem_addr_i = 16'h0200;
    pif.mem_data_i = 16'hDEAD;
    cyc();
    cyc();
    @(negedge clk);
    check_val("abort_pulse_we_n", {31'b0, ram2_we_n}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check_val("abort_we_n", {31'b0, ram2_we_n}, 32'd1);
    check_val("abort_oe_n", {31'b0, ram2_oe_n}, 32'd1);
    check_val("abort_en_n", {31'b0, ram2_en_n}, 32'd1);
    check_val("abort_bus_released", {31'b0, (ram2_data !== 16'hDEAD)}, 32'd1);
    check_val("abort_mem_data", {16'b0, pif.mem_data_o}, 32'd0);
    check_val("abort_inst_nop", {16'b0, pif.if_inst_o}, 32'h0800);
    check_val("abort_sram_kept", {16'b0, sram[10'h200]}, 32'h1234);
    cyc();
    rst = 1'b1;
    idle_bus();
    cyc();
    @(negedge clk);
    check_val("post_abort_fetch", {16'b0, pif.if_inst_o}, 32'h6911);
    check_val("post_abort_addr", {14'b0, ram2_addr}, 32'h0010);
    check_val("post_abort_stall", {31'b0, pif.stallreq_o}, 32'd0);
    check_val("post_abort_mem_data", {16'b0, pif.mem_data_o}, 32'd0);

    do_load(16'h0300, 16'h5555, 16'h6911);
    cyc(); idle_bus();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
